// File: rtl/register_bank.sv
// register_bank: DEPTH general-purpose registers of WIDTH bits sharing one bus.
//
// Ports:
//   register_clock       clock, all state updates on the rising edge
//   register_reset       asynchronous active-low reset
//   bus_bank_input       load data from the bus
//   bus_bank_input_en    load bus_bank_input into register bus_bank_write_sel
//   bus_bank_write_sel   target register for load / in-place op / lock
//   bank_op              in-place op: 00 none, 01 inc, 10 dec, 11 clear
//   bank_lock_en         set the lock bit of register bus_bank_write_sel
//   bus_bank_read_sel    register presented on the bus
//   bus_bank_out_en      drive the bus when high, else high-Z
//   bus_bank_output      tri-state bus output
//   bank_zero            selected read register equals zero
//   bank_wrap            sticky flag: an inc/dec wrapped
//   bank_wrap_clr        synchronous clear of bank_wrap
module register_bank #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              register_clock,
  input  logic              register_reset,
  input  logic [WIDTH-1:0]  bus_bank_input,
  input  logic              bus_bank_input_en,
  input  logic [ADDR_W-1:0] bus_bank_write_sel,
  input  logic [1:0]        bank_op,
  input  logic              bank_lock_en,
  input  logic [ADDR_W-1:0] bus_bank_read_sel,
  input  logic              bus_bank_out_en,
  output logic [WIDTH-1:0]  bus_bank_output,
  output logic              bank_zero,
  output logic              bank_wrap,
  input  logic              bank_wrap_clr
);

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpInc  = 2'b01;
  localparam logic [1:0] OpDec  = 2'b10;
  localparam logic [1:0] OpClr  = 2'b11;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] lock_q;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] cur_val;   // current value of the write target
  logic             wr_hit;    // write_sel names an existing register
  logic             wr_locked;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic             wrap_set;
  logic [WIDTH-1:0] rd_val;

  // Decode by comparison so an out-of-range select never indexes the arrays.
  always_comb begin
    cur_val   = '0;
    wr_hit    = 1'b0;
    wr_locked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus_bank_write_sel == ADDR_W'(i)) begin
        cur_val   = regs_q[i];
        wr_hit    = 1'b1;
        wr_locked = lock_q[i];
      end
    end
  end

  always_comb begin
    wr_val   = cur_val;
    wrap_set = 1'b0;
    if (bus_bank_input_en) begin
      wr_val = bus_bank_input;
    end else begin
      unique case (bank_op)
        OpNone: wr_val = cur_val;
        OpInc: begin
          wr_val   = cur_val + 1'b1;
          wrap_set = (cur_val == '1);
        end
        OpDec: begin
          wr_val   = cur_val - 1'b1;
          wrap_set = (cur_val == '0);
        end
        OpClr: wr_val = '0;
        default: wr_val = cur_val;
      endcase
    end
  end

  assign wr_en  = wr_hit && !wr_locked && (bus_bank_input_en || (bank_op != OpNone));
  // A new wrap beats a same-cycle clear.
  assign wrap_d = (wr_hit && !wr_locked && wrap_set) || (wrap_q && !bank_wrap_clr);

  always_ff @(posedge register_clock or negedge register_reset) begin
    if (!register_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      lock_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (bus_bank_write_sel == ADDR_W'(i))) begin
          regs_q[i] <= wr_val;
        end
        // Lock takes effect after this edge, so a same-cycle write still lands.
        if (bank_lock_en && (bus_bank_write_sel == ADDR_W'(i))) begin
          lock_q[i] <= 1'b1;
        end
      end
      wrap_q <= wrap_d;
    end
  end

  // Out-of-range read selects fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus_bank_read_sel == ADDR_W'(i)) begin
        rd_val = regs_q[i];
      end
    end
  end

  assign bank_zero       = (rd_val == '0);
  assign bank_wrap       = wrap_q;
  assign bus_bank_output = bus_bank_out_en ? rd_val : 'z;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank (WIDTH=16, DEPTH=6).
module tb_register_bank;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 6;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          in_en;
  logic [AW-1:0] wsel;
  logic [1:0]    op;
  logic          lock_en;
  logic [AW-1:0] rsel;
  logic          oe;
  wire  [W-1:0]  bus_out;
  logic          zero;
  logic          wrap;
  logic          wclr;

  int tests;
  int fails;

  register_bank #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .register_clock    (clk),
    .register_reset    (rst_n),
    .bus_bank_input    (din),
    .bus_bank_input_en (in_en),
    .bus_bank_write_sel(wsel),
    .bank_op           (op),
    .bank_lock_en      (lock_en),
    .bus_bank_read_sel (rsel),
    .bus_bank_out_en   (oe),
    .bus_bank_output   (bus_out),
    .bank_zero         (zero),
    .bank_wrap         (wrap),
    .bank_wrap_clr     (wclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied for one cycle; expectations describe outputs seen
  // during that cycle, i.e. state left by earlier vectors.
  typedef struct {
    string         name;
    logic          in_en;
    logic [W-1:0]  din;
    logic [AW-1:0] wsel;
    logic [1:0]    op;
    logic          lock;
    logic          wclr;
    logic [AW-1:0] rsel;
    logic          oe;
    logic [W-1:0]  exp_out;
    logic          exp_zero;
    logic          exp_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic i_en, logic [W-1:0] d, logic [AW-1:0] ws,
                              logic [1:0] o, logic lk, logic wc, logic [AW-1:0] rs,
                              logic en, logic [W-1:0] eo, logic ez, logic ew);
    vec_t v;
    v.name = name; v.in_en = i_en; v.din = d; v.wsel = ws; v.op = o; v.lock = lk;
    v.wclr = wc; v.rsel = rs; v.oe = en; v.exp_out = eo; v.exp_zero = ez; v.exp_wrap = ew;
    return v;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_en = 1'b0; din = '0; wsel = '0; op = 2'b00; lock_en = 1'b0; wclr = 1'b0;
    rsel = '0; oe = 1'b1;
  endtask

  logic [W-1:0] hiz;

  initial begin
    tests = 0;
    fails = 0;
    hiz = 'z;
    rst_n = 1'b0;
    idle_inputs();

    //              name          ien din      ws op    lk wc rs oe  out      z  w
    vecs.push_back(mk("rst_read",   0, 16'h0,    0, 2'b00, 0, 0, 3, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("load_beef",  1, 16'hBEEF, 3, 2'b00, 0, 0, 3, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("read_beef",  0, 16'h0,    0, 2'b00, 0, 0, 3, 1, 16'hBEEF, 0, 0));
    vecs.push_back(mk("hiz",        0, 16'h0,    0, 2'b00, 0, 0, 3, 0, hiz,      0, 0));
    vecs.push_back(mk("load_ffff",  1, 16'hFFFF, 5, 2'b00, 0, 0, 5, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("inc_wrap",   0, 16'h0,    5, 2'b01, 0, 0, 5, 1, 16'hFFFF, 0, 0));
    vecs.push_back(mk("dec_wrap",   0, 16'h0,    5, 2'b10, 0, 0, 5, 1, 16'h0000, 1, 1));
    vecs.push_back(mk("wrap_clr",   0, 16'h0,    0, 2'b00, 0, 1, 5, 1, 16'hFFFF, 0, 1));
    vecs.push_back(mk("wrap_gone",  0, 16'h0,    0, 2'b00, 0, 0, 5, 1, 16'hFFFF, 0, 0));
    vecs.push_back(mk("prio",       1, 16'h1234, 2, 2'b11, 0, 0, 2, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("prio_next",  0, 16'h0,    0, 2'b00, 0, 0, 2, 1, 16'h1234, 0, 0));
    vecs.push_back(mk("lock_load",  1, 16'h00AA, 1, 2'b00, 1, 0, 1, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("lk_load",    1, 16'h5555, 1, 2'b00, 0, 0, 1, 1, 16'h00AA, 0, 0));
    vecs.push_back(mk("lk_clr",     0, 16'h0,    1, 2'b11, 0, 0, 1, 1, 16'h00AA, 0, 0));
    vecs.push_back(mk("lock4",      0, 16'h0,    4, 2'b00, 1, 0, 1, 1, 16'h00AA, 0, 0));
    vecs.push_back(mk("lk4_dec",    0, 16'h0,    4, 2'b10, 0, 0, 4, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("lk4_nowrap", 0, 16'h0,    0, 2'b00, 0, 0, 4, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("oor_write",  1, 16'h7777, 7, 2'b01, 1, 0, 6, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("oor_write6", 0, 16'h0,    6, 2'b10, 0, 0, 6, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("oor_read6",  0, 16'h0,    0, 2'b00, 0, 0, 6, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("oor_read7",  0, 16'h0,    0, 2'b00, 0, 0, 7, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("keep_r3",    0, 16'h0,    0, 2'b00, 0, 0, 3, 1, 16'hBEEF, 0, 0));
    vecs.push_back(mk("keep_r5",    0, 16'h0,    0, 2'b00, 0, 0, 5, 1, 16'hFFFF, 0, 0));
    vecs.push_back(mk("keep_r2",    0, 16'h0,    0, 2'b00, 0, 0, 2, 1, 16'h1234, 0, 0));
    vecs.push_back(mk("keep_r0",    0, 16'h0,    0, 2'b00, 0, 0, 0, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("keep_r1",    0, 16'h0,    0, 2'b00, 0, 0, 1, 1, 16'h00AA, 0, 0));
    // Reg 0 decrements from 0 while the wrap flag is cleared: set wins.
    vecs.push_back(mk("set_vs_clr", 0, 16'h0,    0, 2'b10, 0, 1, 0, 1, 16'h0000, 1, 0));
    vecs.push_back(mk("set_wins",   0, 16'h0,    0, 2'b00, 0, 0, 0, 1, 16'hFFFF, 0, 1));
    vecs.push_back(mk("load_0f0f",  1, 16'h0F0F, 0, 2'b00, 0, 0, 0, 1, 16'hFFFF, 0, 1));
    vecs.push_back(mk("read_0f0f",  0, 16'h0,    0, 2'b00, 0, 0, 0, 1, 16'h0F0F, 0, 1));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[k]) begin
      in_en = vecs[k].in_en; din = vecs[k].din; wsel = vecs[k].wsel; op = vecs[k].op;
      lock_en = vecs[k].lock; wclr = vecs[k].wclr; rsel = vecs[k].rsel; oe = vecs[k].oe;
      #3;
      chk({vecs[k].name, "_out"}, bus_out, vecs[k].exp_out);
      chk({vecs[k].name, "_zero"}, W'(zero), W'(vecs[k].exp_zero));
      chk({vecs[k].name, "_wrap"}, W'(wrap), W'(vecs[k].exp_wrap));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-cycle with reg 0 = 0x0F0F and wrap set.
    idle_inputs();
    rsel = 3'd0;
    #1;
    chk("pre_rst_out", bus_out, 16'h0F0F);
    chk("pre_rst_wrap", W'(wrap), 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", bus_out, 16'h0000);
    chk("async_rst_zero", W'(zero), 16'h0001);
    chk("async_rst_wrap", W'(wrap), 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Locks are cleared by reset: reg 1 loadable again.
    in_en = 1'b1; din = 16'h5555; wsel = 3'd1; rsel = 3'd1;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    #1;
    chk("relock_load", bus_out, 16'h5555);
    chk("relock_zero", W'(zero), 16'h0000);
    oe = 1'b0;
    #1;
    chk("release_hiz", bus_out, hiz);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of DEPTH general-purpose registers of WIDTH bits sharing one system bus. It generalises the single bus register: one address selects the load target and a second selects the register that drives the bus through a tri-state output. It adds in-place increment/decrement/clear operations, per-register write locks, a zero flag and a sticky wrap flag. It sits on the datapath bus alongside the ALU and memory interface, and is sequenced by the control unit.

## Interface
- WIDTH, 16, register and bus width in bits (≥ 2)
- DEPTH, 8, number of registers (2..64; need not be a power of two)
- ADDR_W, $clog2(DEPTH), select width (derived; do not override)

- register_clock  in  1  single clock, all state updates on rising edge
- register_reset  in  1  asynchronous, active-low reset
- bus_bank_input  in  WIDTH  load data from bus
- bus_bank_input_en  in  1  load bus_bank_input into register write_sel
- bus_bank_write_sel  in  ADDR_W  target register for load/op/lock
- bank_op  in  2  in-place op: 00 none, 01 increment, 10 decrement, 11 clear
- bank_lock_en  in  1  set lock bit of register write_sel
- bus_bank_read_sel  in  ADDR_W  register presented on bus
- bus_bank_out_en  in  1  drive bus when high, else high-Z
- bus_bank_output  out  WIDTH  tri-state bus output
- bank_zero  out  1  selected read register equals 0
- bank_wrap  out  1  sticky: an inc/dec wrapped
- bank_wrap_clr  in  1  synchronous clear of bank_wrap

## Operation
- Reset (register_reset low, asynchronous assertion, released synchronously by the system): all registers = 0, all lock bits = 0, bank_wrap = 0. bus_bank_output is high-Z unless bus_bank_out_en is high; it then drives 0. bank_zero = 1.
- Per-cycle priority for register write_sel, evaluated only if its lock bit is 0 and write_sel < DEPTH:
  1. bus_bank_input_en high: reg ← bus_bank_input. bank_op is ignored.
  2. Otherwise bank_op: 01 reg ← reg+1 mod 2^WIDTH; 10 reg ← reg−1 mod 2^WIDTH; 11 reg ← 0; 00 hold.
- Wrap: an increment from all-ones, or a decrement from 0, sets bank_wrap on the same edge. bank_wrap holds until reset or until a cycle with bank_wrap_clr high. If a clear and a new wrap occur in the same cycle, the set wins (bank_wrap = 1).
- Lock: bank_lock_en sets lock[write_sel] at the edge; only reset clears it. The load or op issued in the same cycle as the lock still takes effect; every later load or op to that register is ignored and sets no wrap.
- Out-of-range write_sel (≥ DEPTH): load, op and lock are ignored. Out-of-range read_sel: the output value is 0 and bank_zero = 1.
- bus_bank_output = bus_bank_out_en ? reg[read_sel] : 'z. This path is combinational from current register state. bank_zero is combinational on reg[read_sel], independent of bus_bank_out_en.
- Only one register is written per cycle. All other registers hold.

## Timing
- Load/op latency: 1 cycle. The new value is visible on the output after the edge on which it was written.
- Read-during-write to the same index: the output shows the old value until the edge, then the new value.
- Output enable and high-Z are combinational. There is no cycle of delay from bus_bank_out_en to drive or release.
- bank_wrap updates at the edge of the wrapping op and is visible in the following cycle.
- Asserting reset mid-operation clears state immediately and does not wait for the clock. An op in flight on the reset cycle is lost.

## Test plan
- Reset/load/read: after reset, read reg 3 with out_en=1 → output 0x0000, bank_zero=1. Load 0xBEEF to reg 3, then read 3 → 0xBEEF, bank_zero=0. With out_en=0 → output all Z.
- Increment wrap: load 0xFFFF to reg 5, then op=01 → reg 5 = 0x0000, bank_wrap=1. Next, op=10 → reg 5 = 0xFFFF, bank_wrap stays 1. Pulse bank_wrap_clr → bank_wrap=0.
- Priority: in the same cycle, input_en=1 with data 0x1234 and op=11 on reg 2 → reg 2 = 0x1234. The read of reg 2 shows the old value on that cycle and 0x1234 on the next.
- Lock: load 0x00AA and bank_lock_en on reg 1 in the same cycle → reg 1 = 0x00AA. A later load of 0x5555 and op=11 → reg 1 stays 0x00AA. A later op=10 from a locked 0 does not set wrap. After reset, reg 1 is loadable again.
- Out-of-range: with DEPTH=6, a write to sel 7 leaves every register unchanged. A read of sel 6 → output 0, bank_zero=1.
- Async reset: assert register_reset mid-cycle with reg 0 = 0x0F0F and bank_wrap=1 → reg 0 = 0 and bank_wrap = 0 before the next clock edge. The output drives 0 if out_en=1.
